// File: rtl/asm_pre_approx_pipe.sv
// Multi-lane alphabet-set {1,3,5,7} pre-encoder for the ASM multiplier.
// Each nibble becomes (SEL, SL, zero); a one-deep valid/ready register holds the beat.

module asm_pre_approx_lane #(
  parameter int WIDTH   = 32,
  parameter int NIBBLES = WIDTH / 4,
  parameter int TRUNC_W = $clog2(NIBBLES + 1)
) (
  input  logic [WIDTH-1:0]        opnd_i,
  input  logic [TRUNC_W-1:0]      trunc_i,
  output logic [NIBBLES-1:0][1:0] sel_o,
  output logic [NIBBLES-1:0][1:0] sl_o,
  output logic [NIBBLES-1:0]      zero_o,
  output logic [NIBBLES-1:0]      inexact_o
);
  // Result packing: {zero, inexact, sel, sl}. Non-representable values round to nearest.
  function automatic logic [5:0] enc_nib(input logic [3:0] n);
    logic [5:0] r;
    case (n)
      4'd0:    r = 6'b10_00_00;
      4'd1:    r = 6'b00_00_00;
      4'd2:    r = 6'b00_00_01;
      4'd3:    r = 6'b00_01_00;
      4'd4:    r = 6'b00_00_10;
      4'd5:    r = 6'b00_10_00;
      4'd6:    r = 6'b00_01_01;
      4'd7:    r = 6'b00_11_00;
      4'd8:    r = 6'b00_00_11;
      4'd9:    r = 6'b01_00_11;
      4'd10:   r = 6'b00_10_01;
      4'd11:   r = 6'b01_01_10;
      4'd12:   r = 6'b00_01_10;
      4'd13:   r = 6'b01_01_10;
      4'd14:   r = 6'b00_11_01;
      default: r = 6'b01_11_01;
    endcase
    return r;
  endfunction

  for (genvar j = 0; j < NIBBLES; j++) begin : g_nib
    logic [3:0] nib;
    // j < NIBBLES always, so comparing against the raw control equals the min() clamp.
    assign nib = (TRUNC_W'(j) < trunc_i) ? 4'd0 : opnd_i[j*4 +: 4];
    assign {zero_o[j], inexact_o[j], sel_o[j], sl_o[j]} = enc_nib(nib);
  end
endmodule

module asm_pre_approx_pipe #(
  parameter int WIDTH     = 32,
  parameter int LANES     = 4,
  parameter int NIBBLES   = WIDTH / 4,
  parameter int TRUNC_W   = $clog2(NIBBLES + 1),
  parameter int CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*WIDTH-1:0]       in_data,
  input  logic [TRUNC_W-1:0]           trunc_nib,
  input  logic                         stat_clr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*NIBBLES*2-1:0]   sel_out,
  output logic [LANES*NIBBLES*2-1:0]   sl_out,
  output logic [LANES*NIBBLES-1:0]     zero_out,
  output logic [CNT_WIDTH-1:0]         inexact_cnt
);
  localparam int POP_W = $clog2(LANES * NIBBLES + 1);
  localparam int EXT_W = ((CNT_WIDTH > POP_W) ? CNT_WIDTH : POP_W) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [LANES-1:0][NIBBLES-1:0][1:0] sel_d, sel_q, sl_d, sl_q;
  logic [LANES-1:0][NIBBLES-1:0]      zero_d, zero_q, inx_d;
  logic                               vld_q, accept;
  logic [CNT_WIDTH-1:0]               cnt_d, cnt_q;
  logic [POP_W-1:0]                   pop;
  logic [EXT_W-1:0]                   sum;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    asm_pre_approx_lane #(.WIDTH(WIDTH), .NIBBLES(NIBBLES), .TRUNC_W(TRUNC_W)) u_lane (
      .opnd_i   (in_data[k*WIDTH +: WIDTH]),
      .trunc_i  (trunc_nib),
      .sel_o    (sel_d[k]),
      .sl_o     (sl_d[k]),
      .zero_o   (zero_d[k]),
      .inexact_o(inx_d[k])
    );
  end

  // Ready is forced high in reset, but nothing is accepted there (rst branch wins below).
  assign in_ready = rst || !vld_q || out_ready;
  assign accept   = in_valid && in_ready && !rst;

  always_comb begin
    pop = '0;
    for (int k = 0; k < LANES; k++)
      for (int j = 0; j < NIBBLES; j++)
        pop = pop + POP_W'(inx_d[k][j]);
    sum   = EXT_W'(cnt_q) + EXT_W'(pop);
    cnt_d = cnt_q;
    if (stat_clr)
      cnt_d = '0;
    else if (accept)
      cnt_d = (sum > EXT_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      sel_q  <= '0;
      sl_q   <= '0;
      zero_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        sel_q  <= sel_d;
        sl_q   <= sl_d;
        zero_q <= zero_d;
      end
      if (in_ready) vld_q <= in_valid;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid   = vld_q;
  assign sel_out     = sel_q;
  assign sl_out      = sl_q;
  assign zero_out    = zero_q;
  assign inexact_cnt = cnt_q;
endmodule

// File: tb/tb_asm_pre_approx_pipe.sv
// Scoreboard bench for asm_pre_approx_pipe: driver pushes expected beats, monitor pops on output.
module tb_asm_pre_approx_pipe;
  localparam int W = 8, L = 2, N = 2, CW = 4, TW = 2;
  localparam int SB = L * N * 2, ZB = L * N;

  logic            clk = 1'b0;
  logic            rst, in_valid, in_ready, stat_clr, out_valid, out_ready;
  logic [L*W-1:0]  in_data;
  logic [TW-1:0]   trunc_nib;
  logic [SB-1:0]   sel_out, sl_out;
  logic [ZB-1:0]   zero_out;
  logic [CW-1:0]   inexact_cnt;

  asm_pre_approx_pipe #(.WIDTH(W), .LANES(L), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .trunc_nib(trunc_nib), .stat_clr(stat_clr), .out_valid(out_valid), .out_ready(out_ready),
    .sel_out(sel_out), .sl_out(sl_out), .zero_out(zero_out), .inexact_cnt(inexact_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SB-1:0] sel;
    logic [SB-1:0] sl;
    logic [ZB-1:0] zero;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   n_vec = 0, n_err = 0;
  int   model_cnt = 0;

  // Hand-written alphabet table, index = nibble value.
  int          tsel[16] = '{0, 0, 0, 1, 0, 2, 1, 3, 0, 0, 2, 1, 1, 1, 3, 3};
  int          tsl[16]  = '{0, 0, 1, 0, 2, 0, 1, 0, 3, 3, 1, 2, 2, 2, 1, 1};
  logic [15:0] tinx     = 16'hAA00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compute(input logic [L*W-1:0] d, input int tr, input logic clr, output exp_t e);
    int inx, n;
    inx = 0;
    e = '0;
    for (int k = 0; k < L; k++)
      for (int j = 0; j < N; j++) begin
        n = (j < tr) ? 0 : int'(d[k*W + j*4 +: 4]);
        e.sel[(k*N+j)*2 +: 2] = 2'(tsel[n]);
        e.sl[(k*N+j)*2 +: 2]  = 2'(tsl[n]);
        e.zero[k*N+j]         = (n == 0);
        if (tinx[n]) inx++;
      end
    if (clr) model_cnt = 0;
    else     model_cnt = (model_cnt + inx > 15) ? 15 : model_cnt + inx;
    e.cnt = CW'(model_cnt);
  endtask

  // Called just after a rising edge; returns just after the edge that takes the beat.
  task automatic send(input logic [L*W-1:0] d, input int tr, input logic clr, input bit nostall);
    exp_t e;
    int   w;
    w = 0;
    in_valid = 1'b1; in_data = d; trunc_nib = TW'(tr); stat_clr = clr;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 50) break;
      @(posedge clk); #1;
    end
    if (w > 50) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles want 1");
    end else begin
      compute(d, tr, clr, e);
      q.push_back(e);
    end
    if (nostall) chk("stream_no_stall", 32'(w), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; stat_clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_beat: got out_valid=1 want no beat at %0t", $time);
      end else begin
        e_mon = q[0];
        chk("sel_out", 32'(sel_out), 32'(e_mon.sel));
        chk("sl_out", 32'(sl_out), 32'(e_mon.sl));
        chk("zero_out", 32'(zero_out), 32'(e_mon.zero));
        chk("inexact_cnt", 32'(inexact_cnt), 32'(e_mon.cnt));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF; trunc_nib = '0; stat_clr = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(sel_out), 32'd0);
    chk("rst_zero", 32'(zero_out), 32'd0);
    chk("rst_cnt", 32'(inexact_cnt), 32'd0);
    @(posedge clk); #1;

    // Basic encoding and truncation (lane 0 = 0x9C: sel 0001, sl 1110, one inexact)
    send(16'hE69C, 0, 1'b0, 1'b0);
    send(16'h0B0F, 1, 1'b0, 1'b0);
    send(16'hBD0F, 3, 1'b0, 1'b0);
    send(16'h1234, 0, 1'b0, 1'b0);
    send(16'h0000, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk); #1;

    // Backpressure: A held while B waits, then same-cycle transfer/accept
    out_ready = 1'b0;
    send(16'hA835, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    fork
      send(16'h5577, 0, 1'b0, 1'b0);
      begin repeat (3) @(posedge clk); #1; out_ready = 1'b1; end
    join
    @(posedge clk); #1;

    // Streaming back-to-back
    for (int i = 0; i < 16; i++)
      send({8'(i*37 + 5), 8'(i*11)}, i % 3, 1'b0, 1'b1);
    @(posedge clk); #1;

    // Counter saturation at 15, then clear with an accept in the same cycle
    send(16'h0000, 0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) send(16'h00FF, 0, 1'b0, 1'b1);
    send(16'h00FF, 0, 1'b1, 1'b1);
    send(16'h00FF, 0, 1'b0, 1'b1);
    @(posedge clk); #1;

    // Reset with a held beat pending
    out_ready = 1'b0;
    send(16'h9BDF, 0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    q.delete();
    model_cnt = 0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_sel", 32'(sel_out), 32'd0);
    chk("rst2_sl", 32'(sl_out), 32'd0);
    chk("rst2_cnt", 32'(inexact_cnt), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'hF9C3, 2, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
